// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: widths, PC step, default reset vector,
// and the fetch buffer entry layout.
package cpu_pkg;

  localparam int          INSTR_W          = 32;
  localparam int          BUF_DEPTH        = 2;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Sequential fetch address; 32-bit wrap is intentional.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry in-order buffer between the instruction memory response and the
// IF/ID register. Flush wins over push/pop; head reads as zero when empty.
module fetch_buf
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_push,
  input  fetch_entry_t i_push_entry,
  input  logic         i_pop,
  input  logic         i_flush,
  output logic [1:0]   o_count,
  output fetch_entry_t o_head
);

  fetch_entry_t r_mem [BUF_DEPTH];
  logic         r_rd_ptr;
  logic         r_wr_ptr;
  logic [1:0]   r_count;

  logic         w_pop;
  logic         w_push;

  // Ignore requests that would underflow or overflow the two slots.
  assign w_pop  = i_pop && (r_count != 2'd0);
  assign w_push = i_push && ((r_count != 2'd2) || w_pop);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) r_mem[i] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_entry;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign o_count = r_count;
  assign o_head  = (r_count != 2'd0) ? r_mem[r_rd_ptr] : '0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues sequential fetches under a credit of
// two (outstanding + buffered), buffers in-order responses, and handles
// branch redirects by flushing the buffer and discarding stale responses.
// Optional build macro FETCH_UNIT_ALIGN_CHECK_EN: a misaligned redirect
// target raises a sticky fetch_misalign flag and halts fetching until the
// next aligned redirect. Without it the target's low two bits are cleared.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [31:0]        imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               if_valid,
  output logic [31:0]        if_pc,
  output logic [INSTR_W-1:0] if_instr,
  output logic               fetch_misalign
);

  logic [31:0]  r_pc;
  logic         r_run;
  logic [1:0]   r_outstanding;
  logic [1:0]   r_discard;
  logic         r_misalign;

  logic [1:0]   w_buf_count;
  fetch_entry_t w_head;
  fetch_entry_t w_push_entry;
  logic         w_credit_ok;
  logic         w_hs;
  logic         w_rsp_take;
  logic         w_drop;
  logic         w_push;
  logic         w_pop;
  logic [31:0]  w_rsp_pc;
  logic [31:0]  w_target;
  logic         w_target_misaligned;

`ifdef FETCH_UNIT_ALIGN_CHECK_EN
  assign w_target            = redirect_pc;
  assign w_target_misaligned = (redirect_pc[1:0] != 2'b00);
`else
  assign w_target            = redirect_pc & 32'hFFFF_FFFC;
  assign w_target_misaligned = 1'b0;
`endif

  // r_run holds off the first request until one edge after reset release.
  assign w_credit_ok    = ({1'b0, r_outstanding} + {1'b0, w_buf_count}) < 3'd2;
  assign imem_req_valid = r_run && w_credit_ok && !r_misalign && !redirect_valid;
  assign imem_req_addr  = r_pc;
  assign w_hs           = imem_req_valid && imem_req_ready;

  // Responses are in order, so the oldest outstanding request sits
  // outstanding*4 bytes behind the fetch PC.
  assign w_rsp_take = imem_rsp_valid && (r_outstanding != 2'd0);
  assign w_drop     = w_rsp_take && (r_discard != 2'd0);
  assign w_push     = w_rsp_take && (r_discard == 2'd0) && !redirect_valid;
  assign w_pop      = if_valid && !stall && !redirect_valid;
  assign w_rsp_pc   = r_pc - ({30'b0, r_outstanding} << 2);

  assign w_push_entry.pc    = w_rsp_pc;
  assign w_push_entry.instr = imem_rsp_data;

  // Fetch PC, credit accounting, stale-response discard and misalign flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc          <= RESET_PC;
      r_run         <= 1'b0;
      r_outstanding <= 2'd0;
      r_discard     <= 2'd0;
      r_misalign    <= 1'b0;
    end else begin
      r_run         <= 1'b1;
      r_outstanding <= r_outstanding + {1'b0, w_hs} - {1'b0, w_rsp_take};
      if (redirect_valid) begin
        r_pc       <= w_target;
        r_discard  <= r_outstanding - {1'b0, w_rsp_take};
        r_misalign <= w_target_misaligned;
      end else begin
        if (w_hs)   r_pc      <= next_pc(r_pc);
        if (w_drop) r_discard <= r_discard - 2'd1;
      end
    end
  end

  fetch_buf u_buf (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .i_flush      (redirect_valid),
    .o_count      (w_buf_count),
    .o_head       (w_head)
  );

  assign if_valid       = (w_buf_count != 2'd0);
  assign if_pc          = w_head.pc;
  assign if_instr       = w_head.instr;
  assign fetch_misalign = r_misalign;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by a
// randomized phase, all checked against a stream model (expected request
// and delivery addresses advance by 4 from the last redirect target).
module tb_fetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        fetch_misalign;

  fetch_unit dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .fetch_misalign (fetch_misalign)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory model state
  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;
  req_t        q[$];
  int          cyc = 0;
  int          lat_lo = 0;
  int          lat_hi = 0;
  logic [31:0] rsp_addr = '0;

  // Stream model state
  logic [31:0] exp_req, exp_if, hold_pc, hold_instr, first_pc, last_hs_addr;
  logic [31:0] tgt;
  bit          halted = 0, hold_pend = 0, need_first = 0;
  int          hs_cnt = 0, cons_cnt = 0;
  logic [31:0] hs_log[$];
  logic [31:0] cons_log[$];

  // In-order responder: answers the oldest request once its latency expires.
  always @(negedge clk) begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (reset_n && q.size() > 0 && q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(q[0].addr);
      rsp_addr       = q[0].addr;
      void'(q.pop_front());
    end
  end

  // Monitor: samples pre-edge values and checks them against the stream model.
  always @(posedge clk) begin
    cyc++;
    if (!reset_n) begin
      q.delete();
      exp_req    = RESET_PC_DEFAULT;
      exp_if     = RESET_PC_DEFAULT;
      halted     = 0;
      hold_pend  = 0;
      need_first = 0;
    end else begin
      if (hold_pend) begin
        chk(if_valid, 1, "stall_hold_valid");
        chk(if_pc, hold_pc, "stall_hold_pc");
        chk(if_instr, hold_instr, "stall_hold_instr");
      end
      hold_pend = 0;
      if (!if_valid) begin
        chk(if_pc, 0, "empty_pc_zero");
        chk(if_instr, 0, "empty_instr_zero");
      end
      if (redirect_valid) begin
        chk(imem_req_valid, 0, "req_during_redirect");
`ifdef FETCH_UNIT_ALIGN_CHECK_EN
        tgt    = redirect_pc;
        halted = (redirect_pc[1:0] != 2'b00);
`else
        tgt    = redirect_pc & 32'hFFFF_FFFC;
        halted = 0;
`endif
        exp_req    = tgt;
        exp_if     = tgt;
        need_first = 1;
      end else begin
        if (imem_req_valid && imem_req_ready) begin
          chk(halted, 0, "req_while_misaligned");
          chk(imem_req_addr, exp_req, "req_addr");
          q.push_back('{addr: imem_req_addr, due: cyc + int'($urandom_range(lat_hi, lat_lo))});
          exp_req      = exp_req + 32'd4;
          last_hs_addr = imem_req_addr;
          hs_log.push_back(imem_req_addr);
          hs_cnt++;
        end
        if (if_valid && !stall) begin
          chk(if_pc, exp_if, "if_pc_order");
          chk(if_instr, mem_word(exp_if), "if_instr_data");
          if (need_first) begin
            first_pc   = if_pc;
            need_first = 0;
          end
          cons_log.push_back(if_pc);
          exp_if = exp_if + 32'd4;
          cons_cnt++;
        end
        if (if_valid && stall) begin
          hold_pend  = 1;
          hold_pc    = if_pc;
          hold_instr = if_instr;
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_first(input logic [31:0] exp, input string tag);
    int k = 0;
    while (need_first && k < 60) begin
      step();
      k++;
    end
    chk(need_first, 0, {tag, "_timeout"});
    chk(first_pc, exp, tag);
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] a, held_pc, held_instr, r;
    int          h, k, n0;

    reset_n        = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    repeat (3) step();

    // Reset values
    chk(imem_req_valid, 0, "rst_req_valid");
    chk(if_valid, 0, "rst_if_valid");
    chk(if_pc, 0, "rst_if_pc");
    chk(if_instr, 0, "rst_if_instr");
    chk(fetch_misalign, 0, "rst_misalign");
    chk(imem_req_addr, RESET_PC_DEFAULT, "rst_pc");

    // Reset release, sequential fetch with 1-cycle responses
    reset_n = 1'b1;
    chk(imem_req_valid, 0, "no_req_before_first_edge");
    k = 0;
    while (!imem_rsp_valid && k < 20) begin
      step();
      k++;
    end
    chk(imem_rsp_valid, 1, "first_rsp_timeout");
    chk(if_valid, 0, "latency_same_cycle");
    step();
    chk(if_valid, 1, "latency_next_cycle");
    chk(if_pc, 32'h0, "first_if_pc");
    chk(if_instr, mem_word(32'h0), "first_if_instr");
    repeat (4) step();
    chk(hs_log.size() >= 3, 1, "seq_req_count");
    chk(cons_log.size() >= 3, 1, "seq_cons_count");
    if (hs_log.size() >= 3 && cons_log.size() >= 3) begin
      chk(hs_log[0], 32'h0, "seq_req0");
      chk(hs_log[1], 32'h4, "seq_req1");
      chk(hs_log[2], 32'h8, "seq_req2");
      chk(cons_log[0], 32'h0, "seq_if0");
      chk(cons_log[1], 32'h4, "seq_if1");
      chk(cons_log[2], 32'h8, "seq_if2");
    end

    // Stall with full buffer: no requests, head held, then drains in order
    stall = 1'b1;
    repeat (4) step();
    chk(if_valid, 1, "stall_buf_valid");
    held_pc    = if_pc;
    held_instr = if_instr;
    for (int i = 0; i < 5; i++) begin
      step();
      chk(imem_req_valid, 0, "stall_full_no_req");
      chk(if_pc, held_pc, "stall_pc_held");
      chk(if_instr, held_instr, "stall_instr_held");
    end
    n0    = cons_cnt;
    stall = 1'b0;
    repeat (3) step();
    chk(cons_cnt - n0 >= 2, 1, "stall_drain_count");
    if (cons_log.size() > n0) chk(cons_log[n0], held_pc, "stall_drain_head");

    // Ready low: address stable, PC does not advance
    lat_lo         = 6;
    lat_hi         = 6;
    imem_req_ready = 1'b0;
    step();
    a = imem_req_addr;
    h = hs_cnt;
    repeat (3) begin
      step();
      chk(imem_req_addr, a, "ready_low_addr_stable");
    end
    chk(hs_cnt, h, "ready_low_no_handshake");
    repeat (8) step();
    chk(if_valid, 0, "drained_empty");

    // Two outstanding (0x10, 0x14) then redirect to 0x100
    imem_req_ready = 1'b1;
    redirect(32'h10);
    h = hs_cnt;
    k = 0;
    while (hs_cnt < h + 2 && k < 10) begin
      step();
      k++;
    end
    chk(hs_cnt, h + 2, "two_outstanding_issued");
    chk(last_hs_addr, 32'h14, "two_outstanding_last");
    chk(if_valid, 0, "two_outstanding_unanswered");
    redirect(32'h100);
    wait_first(32'h100, "redirect_drop_first");

    // Redirect coinciding with response for 0x20 and stall
    lat_lo = 0;
    lat_hi = 0;
    redirect(32'h20);
    k = 0;
    while (!(imem_rsp_valid && rsp_addr == 32'h20) && k < 20) begin
      step();
      k++;
    end
    chk(imem_rsp_valid && rsp_addr == 32'h20, 1, "rsp_0x20_seen");
    stall = 1'b1;
    redirect(32'h300);
    chk(if_valid, 0, "redir_rsp_stall_empty");
    chk(imem_req_addr, 32'h300, "redir_rsp_stall_pc");
    stall = 1'b0;
    wait_first(32'h300, "redir_rsp_stall_first");

    // PC wrap at the top of the address space
    redirect(32'hFFFF_FFFC);
    h = hs_cnt;
    k = 0;
    while (hs_cnt == h && k < 10) begin
      step();
      k++;
    end
    chk(last_hs_addr, 32'hFFFF_FFFC, "wrap_req_addr");
    chk(imem_req_addr, 32'h0, "wrap_next_addr");
    wait_first(32'hFFFF_FFFC, "wrap_first");
    repeat (4) step();

    // Randomized traffic with a mid-run reset
    lat_lo = 0;
    lat_hi = 3;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        redirect_valid = 1'b0;
        reset_n        = 1'b0;
        step();
        chk(imem_req_valid, 0, "rst_mid_req_valid");
        chk(if_valid, 0, "rst_mid_if_valid");
        chk(imem_req_addr, RESET_PC_DEFAULT, "rst_mid_pc");
        step();
        reset_n = 1'b1;
      end
      imem_req_ready = ($urandom_range(3, 0) != 0);
      stall          = ($urandom_range(2, 0) == 0);
      if ($urandom_range(15, 0) == 0) begin
        r = $urandom;
`ifdef FETCH_UNIT_ALIGN_CHECK_EN
        redirect_pc = r & 32'hFFFF_FFFC;
`else
        redirect_pc = r;
`endif
        redirect_valid = 1'b1;
      end else begin
        redirect_valid = 1'b0;
      end
      step();
    end
    redirect_valid = 1'b0;
    stall          = 1'b0;
    imem_req_ready = 1'b1;
    lat_hi         = 0;
    repeat (6) step();

`ifdef FETCH_UNIT_ALIGN_CHECK_EN
    // Misaligned redirect halts fetching until an aligned redirect
    redirect(32'h102);
    chk(fetch_misalign, 1, "misalign_set");
    h = hs_cnt;
    repeat (6) begin
      step();
      chk(imem_req_valid, 0, "misalign_no_req");
    end
    chk(hs_cnt, h, "misalign_no_handshake");
    chk(if_valid, 0, "misalign_buf_empty");
    chk(fetch_misalign, 1, "misalign_sticky");
    redirect(32'h200);
    chk(fetch_misalign, 0, "misalign_cleared");
    wait_first(32'h200, "misalign_resume");
`else
    // Without the check, low target bits are ignored
    redirect(32'h102);
    chk(fetch_misalign, 0, "misalign_tied_low");
    wait_first(32'h100, "unaligned_forced");
`endif

    repeat (5) step();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
